// File: rtl/arb2_bus8_pkg.sv
// Shared definitions for the two-source byte arbiter: FSM encodings,
// the idle-release limit and the saturating beat-count helper.
package arb2_bus8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    // Idle cycles tolerated in a grant before the third one forces release.
    localparam logic [1:0] IDLE_LIMIT = 2'd2;

    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] lim);
        return (val >= lim) ? lim : (val + 8'd1);
    endfunction

endpackage

// File: rtl/mux8.sv
// Existing 2:1 byte selector: enable=0 passes in1, enable=1 passes in2.
module mux8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       enable,
    output logic [7:0] out
);

    assign out = enable ? in2 : in1;

endmodule

// File: rtl/arb2_bus8.sv
// Round-robin arbiter for two byte-stream sources sharing one sink, with a
// hold limit under contention and release of a grant whose owner goes quiet.
module arb2_bus8
    import arb2_bus8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ack0,
    output logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic       out_last
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] idle_q, idle_d;

    logic       granted_s;
    logic       cur_req_s;
    logic       cur_last_s;
    logic       oth_req_s;
    logic [7:0] hold_inc_s;
    logic       release_s;

    assign granted_s  = (state_q != ST_IDLE);
    assign cur_req_s  = (state_q == ST_G1) ? req1  : req0;
    assign cur_last_s = (state_q == ST_G1) ? last1 : last0;
    assign oth_req_s  = (state_q == ST_G1) ? req0  : req1;
    assign hold_inc_s = sat_inc(hold_q, HOLD_LIM);

    // Next-state, pointer and counter logic for arbitration and release.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idle_d    = idle_q;
        release_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        state_d = ptr_q ? ST_G1 : ST_G0;
                    end else begin
                        state_d = req1 ? ST_G1 : ST_G0;
                    end
                    hold_d = 8'd0;
                    idle_d = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_G0, ST_G1: begin
                if (cur_req_s) begin
                    idle_d = 2'd0;
                    if (out_ready) begin
                        hold_d    = hold_inc_s;
                        release_s = cur_last_s || ((hold_inc_s == HOLD_LIM) && oth_req_s);
                    end else begin
                        release_s = 1'b0;
                    end
                end else if (idle_q == IDLE_LIMIT) begin
                    release_s = 1'b1;
                end else begin
                    idle_d = idle_q + 2'd1;
                end
                // The other source always takes priority for the next tie.
                if (release_s) begin
                    ptr_d  = (state_q == ST_G0);
                    hold_d = 8'd0;
                    idle_d = 2'd0;
                    if (oth_req_s) begin
                        state_d = (state_q == ST_G0) ? ST_G1 : ST_G0;
                    end else if (cur_req_s) begin
                        state_d = state_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 8'd0;
                idle_d  = 2'd0;
            end
        endcase
    end

    // State, pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            hold_q  <= 8'd0;
            idle_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
        end
    end

    assign gnt0      = (state_q == ST_G0);
    assign gnt1      = (state_q == ST_G1);
    assign out_src   = (state_q == ST_G1);
    // Handshake is suppressed while reset is asserted so an abandoned burst gets no ack.
    assign out_valid = reset_n && granted_s && cur_req_s;
    assign ack0      = reset_n && (state_q == ST_G0) && req0 && out_ready;
    assign ack1      = reset_n && (state_q == ST_G1) && req1 && out_ready;
    assign out_last  = granted_s && cur_last_s;

    mux8 u_mux8 (
        .in1    (data0),
        .in2    (data1),
        .enable (out_src),
        .out    (out_data)
    );

endmodule

// File: tb/tb_arb2_bus8.sv
// Randomized bench for arb2_bus8: a behavioural arbiter model predicts each
// cycle's grant and the beats that should be accepted; a monitor checks them.
module tb_arb2_bus8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1, last0, last1, out_ready;
    logic [7:0] data0, data1;
    logic       ack0, ack1, gnt0, gnt1, out_valid, out_src, out_last;
    logic [7:0] out_data;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t beat_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    chk_en   = 1'b0;

    // Expected per-cycle outputs, written by the stimulus process.
    int   exp_owner = -1;
    logic exp_valid, exp_last, exp_ack0, exp_ack1;

    // Reference model state.
    int owner = -1;
    int beats = 0;
    int quiet = 0;
    int prio  = 0;

    always #5 clk = ~clk;

    arb2_bus8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .last0     (last0),
        .last1     (last1),
        .ack0      (ack0),
        .ack1      (ack1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Predict this cycle's outputs from the current model state, then advance it.
    task automatic model_step();
        logic r[2], l[2];
        logic [7:0] d[2];
        int x, y;
        bit done;
        r[0] = req0; r[1] = req1; l[0] = last0; l[1] = last1; d[0] = data0; d[1] = data1;
        exp_owner = owner;
        exp_last  = (owner >= 0) ? l[owner] : 1'b0;
        exp_valid = (owner >= 0) && reset_n && r[owner];
        exp_ack0  = (owner == 0) && reset_n && r[0] && out_ready;
        exp_ack1  = (owner == 1) && reset_n && r[1] && out_ready;
        if (!reset_n) begin
            owner = -1; beats = 0; quiet = 0; prio = 0;
        end else if (owner < 0) begin
            if (r[0] || r[1]) begin
                owner = (r[0] && r[1]) ? prio : (r[1] ? 1 : 0);
                beats = 0; quiet = 0;
            end
        end else begin
            x = owner; y = 1 - owner; done = 1'b0;
            if (r[x]) begin
                quiet = 0;
                if (out_ready) begin
                    beat_q.push_back('{src: x[0], data: d[x], last: l[x]});
                    beats = (beats + 1 > MH) ? MH : beats + 1;
                    done  = l[x] || (beats == MH && r[y]);
                end
            end else begin
                quiet++;
                done = (quiet == 3);
            end
            if (done) begin
                prio  = y;
                owner = r[y] ? y : (r[x] ? x : -1);
                beats = 0; quiet = 0;
            end
        end
    endtask

    // Monitor: per-cycle grant/handshake checks and scoreboard pops on every ack.
    always @(negedge clk) begin
        beat_t b;
        if (chk_en) begin
            check1("gnt0", gnt0, exp_owner == 0);
            check1("gnt1", gnt1, exp_owner == 1);
            check1("out_src", out_src, exp_owner == 1);
            check1("out_valid", out_valid, exp_valid);
            check1("out_last", out_last, exp_last);
            check1("ack0", ack0, exp_ack0);
            check1("ack1", ack1, exp_ack1);
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== (out_src ? data1 : data0)) begin
                    failures++;
                    $display("FAIL out_data_path at %0t: got %02h", $time, out_data);
                end
            end
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                checks++;
                if (beat_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected at %0t: src=%0b data=%02h", $time, out_src, out_data);
                end else begin
                    b = beat_q.pop_front();
                    if (out_src !== b.src || out_data !== b.data || out_last !== b.last) begin
                        failures++;
                        $display("FAIL beat at %0t: got src=%0b data=%02h last=%0b expected src=%0b data=%02h last=%0b",
                                 $time, out_src, out_data, out_last, b.src, b.data, b.last);
                    end
                end
            end
        end
    end

    // Stimulus: phases bias request, last, ready and reset rates.
    initial begin
        int p_req, p_last, p_rdy, p_rst;
        bit solo;
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b0;
        model_step();
        @(posedge clk); #1;
        chk_en = 1'b1;
        // Directed: single one-beat burst from source 0.
        reset_n = 1'b1; req0 = 1'b1; data0 = 8'hA5; last0 = 1'b1; out_ready = 1'b1;
        model_step();
        @(posedge clk); #1;
        model_step();
        @(posedge clk); #1;
        req0 = 1'b0; last0 = 1'b0;
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_req = 95; p_last = 60; p_rdy = 100; p_rst = 0; solo = 1'b0; end
                1: begin p_req = 95; p_last = 3;  p_rdy = 90;  p_rst = 0; solo = 1'b0; end
                2: begin p_req = 97; p_last = 3;  p_rdy = 90;  p_rst = 0; solo = 1'b1; end
                3: begin p_req = 90; p_last = 10; p_rdy = 40;  p_rst = 0; solo = 1'b0; end
                4: begin p_req = 55; p_last = 10; p_rdy = 80;  p_rst = 0; solo = 1'b0; end
                default: begin p_req = 80; p_last = 20; p_rdy = 70; p_rst = 3; solo = 1'b0; end
            endcase
            for (int c = 0; c < 500; c++) begin
                reset_n   = ($urandom_range(99) >= p_rst);
                req0      = ($urandom_range(99) < p_req);
                req1      = solo ? 1'b0 : ($urandom_range(99) < p_req);
                last0     = ($urandom_range(99) < p_last);
                last1     = ($urandom_range(99) < p_last);
                data0     = 8'($urandom);
                data1     = 8'($urandom);
                out_ready = ($urandom_range(99) < p_rdy);
                model_step();
                @(posedge clk); #1;
            end
        end
        reset_n = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            model_step();
            @(posedge clk); #1;
        end
        checks++;
        if (beat_q.size() != 0) begin
            failures++;
            $display("FAIL beats_outstanding: got %0d expected 0", beat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
